vstore_bank_sequencer: RTL and testbench

//  Multi-lane, multi-bank store sequencer between the EX/MEM stage and the banked data memory.

---
 rtl/vstore_bank_sequencer.sv | 183 ++++++++++++++++++
 tb/tb_vstore_bank_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vstore_bank_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : vstore_bank_sequencer                                            |
// | Brief   : Multi-lane scalar/vector store sequencer onto a banked data      |
// |           memory. Builds byte enables and shifted data per lane, grants    |
// |           the lowest pending lane per bank each cycle, flags misalignment. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+

`ifndef DATAMEM_BITS
`define DATAMEM_BITS 12
`endif

module vstore_bank_sequencer #(
  parameter int NUM_LANES = 4,
  parameter int NUM_BANKS = 4,
  parameter int ADDR_W    = `DATAMEM_BITS
) (
  input  logic                          clk,
  input  logic                          nrst,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic                          req_vector,
  input  logic [1:0]                    req_size,
  input  logic [NUM_LANES-1:0]          req_mask,
  input  logic [NUM_LANES*ADDR_W-1:0]   req_addr,
  input  logic [NUM_LANES*2-1:0]        req_boff,
  input  logic [NUM_LANES*32-1:0]       req_data,
  input  logic                          mem_stall,
  output logic [NUM_BANKS*4-1:0]        bank_we,
  output logic [NUM_BANKS*ADDR_W-1:0]   bank_addr,
  output logic [NUM_BANKS*32-1:0]       bank_data,
  output logic                          busy,
  output logic                          done,
  output logic                          misalign_err
);

  localparam int BB = $clog2(NUM_BANKS);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [0:0]                  r_state;
  logic [0:0]                  w_state_nxt;
  logic [NUM_LANES*ADDR_W-1:0] r_addr;
  logic [NUM_LANES*2-1:0]      r_boff;
  logic [NUM_LANES*32-1:0]     r_data;
  logic [1:0]                  r_size;
  logic [NUM_LANES-1:0]        r_pending;
  logic                        r_err;

  logic                        w_accept;
  logic                        w_done;
  logic [NUM_LANES-1:0]        w_active;
  logic [NUM_LANES-1:0]        w_misal;
  logic [NUM_LANES-1:0]        w_granted;
  logic [3:0]                  w_lane_we   [NUM_LANES];
  logic [31:0]                 w_lane_data [NUM_LANES];

  assign w_accept = req_valid && (r_state == ST_IDLE);
  // A scalar store only ever uses lane 0, whatever the mask says.
  assign w_active = req_vector ? req_mask : NUM_LANES'(1);

  generate
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      logic [1:0]  w_boff_in;
      logic [1:0]  w_boff_q;
      logic [31:0] w_d_q;
      logic [31:0] w_d_ext;

      assign w_boff_in  = req_boff[2*i +: 2];
      assign w_misal[i] = (req_size == 2'd3) ||
                          ((req_size == 2'd1) && w_boff_in[0]) ||
                          ((req_size == 2'd2) && (w_boff_in != 2'd0));

      assign w_boff_q = r_boff[2*i +: 2];
      assign w_d_q    = r_data[32*i +: 32];

      // Size-dependent zero extension and byte enables (we bit 3 = byte lane 0).
      always_comb begin
        w_d_ext      = 32'd0;
        w_lane_we[i] = 4'b0000;
        case (r_size)
          2'd0: begin
            w_d_ext      = {24'd0, w_d_q[7:0]};
            w_lane_we[i] = 4'b1000 >> w_boff_q;
          end
          2'd1: begin
            w_d_ext      = {16'd0, w_d_q[15:0]};
            w_lane_we[i] = 4'b1100 >> w_boff_q;
          end
          2'd2: begin
            w_d_ext      = w_d_q;
            w_lane_we[i] = 4'b1111;
          end
          default: begin
            w_d_ext      = 32'd0;
            w_lane_we[i] = 4'b0000;
          end
        endcase
      end

      assign w_lane_data[i] = w_d_ext << {w_boff_q, 3'b000};
    end
  endgenerate

  // Per-bank arbiter: lowest-index pending lane targeting each bank wins.
  always_comb begin
    logic [NUM_BANKS-1:0] taken;
    taken     = '0;
    w_granted = '0;
    bank_we   = '0;
    bank_addr = '0;
    bank_data = '0;
    if ((r_state == ST_ISSUE) && !mem_stall) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
          if (r_pending[i] && !taken[b] &&
              (r_addr[i*ADDR_W +: BB] == BB'(b))) begin
            taken[b]                    = 1'b1;
            w_granted[i]                = 1'b1;
            bank_we[b*4 +: 4]           = w_lane_we[i];
            bank_addr[b*ADDR_W +: ADDR_W] = r_addr[i*ADDR_W +: ADDR_W];
            bank_data[b*32 +: 32]       = w_lane_data[i];
          end
        end
      end
    end
  end

  assign w_done = (r_state == ST_ISSUE) && !mem_stall &&
                  ((r_pending & ~w_granted) == '0);

  // State register.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_accept) w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (w_done)   w_state_nxt = ST_IDLE;
      default:                w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake and status outputs decoded from state.
  always_comb begin
    req_ready    = (r_state == ST_IDLE);
    busy         = (r_state == ST_ISSUE);
    done         = w_done;
    misalign_err = w_done && r_err;
  end

  // Request latch and pending-lane bookkeeping.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_addr    <= '0;
      r_boff    <= '0;
      r_data    <= '0;
      r_size    <= 2'd0;
      r_pending <= '0;
      r_err     <= 1'b0;
    end else if (w_accept) begin
      r_addr    <= req_addr;
      r_boff    <= req_boff;
      r_data    <= req_data;
      r_size    <= req_size;
      r_pending <= w_active & ~w_misal;
      r_err     <= |(w_active & w_misal);
    end else if ((r_state == ST_ISSUE) && !mem_stall) begin
      r_pending <= r_pending & ~w_granted;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_vstore_bank_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_vstore_bank_sequencer                                         |
// | Brief   : Scoreboard bench for vstore_bank_sequencer with directed stores. |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_vstore_bank_sequencer;

  localparam int NL = 4;
  localparam int NB = 4;
  localparam int AW = 12;

  logic              clk = 1'b0;
  logic              nrst = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_vector = 1'b0;
  logic [1:0]        req_size = 2'd0;
  logic [NL-1:0]     req_mask = '0;
  logic [NL*AW-1:0]  req_addr = '0;
  logic [NL*2-1:0]   req_boff = '0;
  logic [NL*32-1:0]  req_data = '0;
  logic              mem_stall = 1'b0;
  logic [NB*4-1:0]   bank_we;
  logic [NB*AW-1:0]  bank_addr;
  logic [NB*32-1:0]  bank_data;
  logic              busy;
  logic              done;
  logic              misalign_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0]  we;
    logic [47:0]  addr;
    logic [127:0] data;
    logic         dn;
    logic         er;
  } exp_t;

  exp_t exp_q[$];

  vstore_bank_sequencer #(.NUM_LANES(NL), .NUM_BANKS(NB), .ADDR_W(AW)) dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready), .req_vector(req_vector),
    .req_size(req_size), .req_mask(req_mask), .req_addr(req_addr),
    .req_boff(req_boff), .req_data(req_data), .mem_stall(mem_stall),
    .bank_we(bank_we), .bank_addr(bank_addr), .bank_data(bank_data),
    .busy(busy), .done(done), .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Expected issue cycle; banks listed 0..3.
  task automatic expect_cycle(input logic [15:0] we,
                              input logic [11:0] a0, a1, a2, a3,
                              input logic [31:0] d0, d1, d2, d3,
                              input logic dn, input logic er);
    exp_t e;
    e.we   = we;
    e.addr = {a3, a2, a1, a0};
    e.data = {d3, d2, d1, d0};
    e.dn   = dn;
    e.er   = er;
    exp_q.push_back(e);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ready"}, 128'(req_ready), 128'(1));
    chk({tag, "_busy"},  128'(busy), 128'(0));
    chk({tag, "_we"},    128'(bank_we), 128'(0));
    chk({tag, "_addr"},  128'(bank_addr), 128'(0));
    chk({tag, "_data"},  128'(bank_data), 128'(0));
    chk({tag, "_done"},  128'(done), 128'(0));
    chk({tag, "_err"},   128'(misalign_err), 128'(0));
  endtask

  // Issue one request and hold mem_stall per stall_pat[k] in the k-th cycle after accept.
  task automatic run_req(input string tag, input logic vec, input logic [1:0] sz,
                         input logic [3:0] msk, input logic [47:0] ad,
                         input logic [7:0] bo, input logic [127:0] dt,
                         input logic [7:0] stall_pat);
    bit fin;
    int k;
    @(posedge clk); #1;
    chk({tag, "_ready_before_accept"}, 128'(req_ready), 128'(1));
    req_valid  = 1'b1;
    req_vector = vec;
    req_size   = sz;
    req_mask   = msk;
    req_addr   = ad;
    req_boff   = bo;
    req_data   = dt;
    @(posedge clk); #1;
    req_valid = 1'b0;
    fin = 1'b0;
    k = 0;
    while (!fin && k < 8) begin
      mem_stall = stall_pat[k];
      @(negedge clk);
      if (done === 1'b1) fin = 1'b1;
      @(posedge clk); #1;
      k++;
    end
    mem_stall = 1'b0;
    checks++;
    if (!fin) begin
      errors++;
      $display("FAIL %s_timeout: done not seen within %0d cycles, required done=1", tag, k);
    end
  endtask

  // Monitor: every issue cycle the DUT presents is compared against the next expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: issue cycle with bank_we=%h done=%b, required no issue",
                   bank_we, done);
        end else begin
          e = exp_q.pop_front();
          chk("sb_we",   128'(bank_we),      128'(e.we));
          chk("sb_addr", 128'(bank_addr),    128'(e.addr));
          chk("sb_data", 128'(bank_data),    128'(e.data));
          chk("sb_done", 128'(done),         128'(e.dn));
          chk("sb_err",  128'(misalign_err), 128'(e.er));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check_idle("reset");
    nrst = 1'b1;

    // 1: scalar sw to bank1; other lanes carry junk that must be ignored.
    expect_cycle(16'h00F0, 12'h0, 12'h005, 12'h0, 12'h0,
                 32'h0, 32'hDEADBEEF, 32'h0, 32'h0, 1'b1, 1'b0);
    run_req("t1_sw", 1'b0, 2'd2, 4'b1111, {12'h003, 12'h002, 12'h001, 12'h005},
            8'h00, {32'h4, 32'h3, 32'h2, 32'hDEADBEEF}, 8'h00);

    // 2: scalar sb, boff=3 -> top byte lane of bank2.
    expect_cycle(16'h0100, 12'h0, 12'h0, 12'h002, 12'h0,
                 32'h0, 32'h0, 32'hAB000000, 32'h0, 1'b1, 1'b0);
    run_req("t2_sb", 1'b0, 2'd0, 4'b0000, {12'h0, 12'h0, 12'h0, 12'h002},
            8'b00_00_00_11, {96'h0, 32'h123456AB}, 8'h00);

    // 3: vector sw, one lane per bank -> single cycle.
    expect_cycle(16'hFFFF, 12'h010, 12'h011, 12'h012, 12'h013,
                 32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444, 1'b1, 1'b0);
    run_req("t3_vsw", 1'b1, 2'd2, 4'b1111, {12'h013, 12'h012, 12'h011, 12'h010},
            8'h00, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 8'h00);

    // 4: three lanes collide on bank0 -> serialised over three cycles.
    expect_cycle(16'h00FF, 12'h010, 12'h011, 12'h0, 12'h0,
                 32'hA0A0A0A0, 32'hD3D3D3D3, 32'h0, 32'h0, 1'b0, 1'b0);
    expect_cycle(16'h000F, 12'h014, 12'h0, 12'h0, 12'h0,
                 32'hB1B1B1B1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    expect_cycle(16'h000F, 12'h018, 12'h0, 12'h0, 12'h0,
                 32'hC2C2C2C2, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    run_req("t4_conflict", 1'b1, 2'd2, 4'b1111, {12'h011, 12'h018, 12'h014, 12'h010},
            8'h00, {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0}, 8'h00);

    // 4b: same with a stall in the second issue cycle.
    expect_cycle(16'h00FF, 12'h010, 12'h011, 12'h0, 12'h0,
                 32'hA0A0A0A0, 32'hD3D3D3D3, 32'h0, 32'h0, 1'b0, 1'b0);
    expect_cycle(16'h0000, 12'h0, 12'h0, 12'h0, 12'h0,
                 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    expect_cycle(16'h000F, 12'h014, 12'h0, 12'h0, 12'h0,
                 32'hB1B1B1B1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    expect_cycle(16'h000F, 12'h018, 12'h0, 12'h0, 12'h0,
                 32'hC2C2C2C2, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    run_req("t4_stall", 1'b1, 2'd2, 4'b1111, {12'h011, 12'h018, 12'h014, 12'h010},
            8'h00, {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0}, 8'b0000_0010);

    // 5: vector sh, lane0 misaligned (dropped), lane2 at boff=2.
    expect_cycle(16'h0300, 12'h0, 12'h0, 12'h022, 12'h0,
                 32'h0, 32'h0, 32'hF00D0000, 32'h0, 1'b1, 1'b1);
    run_req("t5_vsh", 1'b1, 2'd1, 4'b0101, {12'h023, 12'h022, 12'h021, 12'h020},
            8'b00_10_00_01, {32'h99999999, 32'hCAFEF00D, 32'h88888888, 32'h11112222}, 8'h00);

    // 6: four byte stores to the same word, serialised in lane order on bank0.
    expect_cycle(16'h0008, 12'h030, 12'h0, 12'h0, 12'h0,
                 32'h00000011, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    expect_cycle(16'h0004, 12'h030, 12'h0, 12'h0, 12'h0,
                 32'h00002200, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    expect_cycle(16'h0002, 12'h030, 12'h0, 12'h0, 12'h0,
                 32'h00330000, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    expect_cycle(16'h0001, 12'h030, 12'h0, 12'h0, 12'h0,
                 32'h44000000, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    run_req("t6_samew", 1'b1, 2'd0, 4'b1111, {12'h030, 12'h030, 12'h030, 12'h030},
            8'b11_10_01_00, {32'hFFFFFF44, 32'hFFFFFF33, 32'hFFFFFF22, 32'hFFFFFF11}, 8'h00);

    // 7: empty mask -> one cycle, no writes, done.
    expect_cycle(16'h0000, 12'h0, 12'h0, 12'h0, 12'h0,
                 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0);
    run_req("t7_empty", 1'b1, 2'd2, 4'b0000, {12'h013, 12'h012, 12'h011, 12'h010},
            8'h00, {128{1'b1}}, 8'h00);

    // 8: reserved size -> no write, error flagged.
    expect_cycle(16'h0000, 12'h0, 12'h0, 12'h0, 12'h0,
                 32'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b1);
    run_req("t8_size3", 1'b0, 2'd3, 4'b0000, {36'h0, 12'h007},
            8'h00, {96'h0, 32'h12345678}, 8'h00);

    // 9: reset in the middle of the conflicting request drops it.
    expect_cycle(16'h00FF, 12'h010, 12'h011, 12'h0, 12'h0,
                 32'hA0A0A0A0, 32'hD3D3D3D3, 32'h0, 32'h0, 1'b0, 1'b0);
    expect_cycle(16'h000F, 12'h014, 12'h0, 12'h0, 12'h0,
                 32'hB1B1B1B1, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0);
    @(posedge clk); #1;
    req_valid  = 1'b1;
    req_vector = 1'b1;
    req_size   = 2'd2;
    req_mask   = 4'b1111;
    req_addr   = {12'h011, 12'h018, 12'h014, 12'h010};
    req_boff   = 8'h00;
    req_data   = {32'hD3D3D3D3, 32'hC2C2C2C2, 32'hB1B1B1B1, 32'hA0A0A0A0};
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b0;
    @(posedge clk); #1;
    check_idle("midreset");
    nrst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midreset_stays_idle", 128'(busy), 128'(0));

    chk("sb_drained", 128'(exp_q.size()), 128'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
